comparator_sweep_checker: RTL and testbench
===========================================

// Module: comparator_sweep_checker
// PURPOSE
//  Self-checking driver for the 4-bit magnitude comparator; the driving and checking side of its A/B -> AeB/AgB/AlB interface.
//  Sweeps every (A,B) pair, waits for the DUT outputs to settle, then checks AeB/AgB/AlB against an internal model.
//  Counts mismatches and captures the first failing vector. Used for on-chip BIST and as a reusable bench component.
// PARAMETERS
//  WIDTH   4  operand width; sweep covers 2^(2*WIDTH) pairs
//  SETTLE  1  idle cycles between driving A_o/B_o and sampling flags (0 allowed)
//  ERR_W   16 width of err_count; the counter saturates at 2^ERR_W-1
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous active-low reset
//  start        in   1      level; sampled only in IDLE or DONE
//  A_o          out  WIDTH  operand A to DUT (registered)
//  B_o          out  WIDTH  operand B to DUT (registered)
//  AeB_i        in   1      DUT A==B flag
//  AgB_i        in   1      DUT A>B flag
//  AlB_i        in   1      DUT A<B flag
//  busy         out  1      sweep in progress
//  done         out  1      sweep complete; held until restart or reset
//  pass         out  1      done && err_count==0
//  err_count    out  ERR_W  mismatching vectors, saturating
//  first_err_a  out  WIDTH  A of first mismatch
//  first_err_b  out  WIDTH  B of first mismatch
//  first_err_f  out  3      observed {AeB,AgB,AlB} at first mismatch
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous, active-low (rst_n sampled on clk rising edge).
//  - Reset: all outputs 0; state IDLE; any run in progress is abandoned immediately.
//  - FSM states: IDLE, WAIT, CHECK, DONE.
//    IDLE --start--> WAIT (SETTLE>0) or CHECK (SETTLE==0).
//    On that edge: A_o=0, B_o=0, err_count=0, first_err_*=0, busy=1, done=0.
//    WAIT: counts SETTLE cycles, then -> CHECK.
//    CHECK: samples flags for one cycle. Expected flags are {A_o==B_o, A_o>B_o, A_o<B_o}, unsigned.
//      Any bit difference is a mismatch, including zero-hot and multi-hot outputs.
//      On mismatch: err_count++ (saturating). If this is the first mismatch, latch A_o, B_o and the flags.
//      Then {A_o,B_o} advances as one 2*WIDTH-bit counter (B_o is the LSBs).
//      If the counter wraps to 0 -> DONE (busy=0, done=1). Otherwise -> WAIT, or stay in CHECK when SETTLE==0.
//    DONE: outputs held; start -> restart exactly as from IDLE.
//  - Per-vector period is SETTLE+1 cycles. busy is high for 2^(2*WIDTH)*(SETTLE+1) cycles.
//  - busy rises on the edge after start is sampled; done and pass rise on the edge after the last CHECK.
//  - start is ignored while busy (no restart, no error).
//  - A_o/B_o change only on CHECK->next edges, so they are stable through WAIT.
//  - pass is combinational from done and err_count; 0 whenever done=0.
// STRUCTURE
//  - Package comparator_pkg:
//    - state encoding constants (IDLE=0, WAIT=1, CHECK=2, DONE=3)
//    - flag bit indices (EQ=2, GT=1, LT=0)
//    - function exp_flags(a,b) returning the 3-bit expected vector
//  - Sub-module cmp_vector_gen: 2*WIDTH-bit operand counter with clear, advance and wrap outputs.
//  - Top level holds the FSM, settle counter, saturating error counter and first-error capture.
// TESTING
//  1. WIDTH=4, SETTLE=1, correct comparator4bit attached, start pulse
//     -> busy for 512 cycles; done=1, err_count=0, pass=1.
//  2. DUT AgB forced 0, same run
//     -> err_count=120; first_err_a=1, first_err_b=0, first_err_f=3'b000; pass=0.
//  3. DUT AgB/AlB swapped
//     -> err_count=240; first_err_a=0, first_err_b=1, first_err_f=3'b010.
//  4. ERR_W=4, flags tied 3'b000
//     -> err_count saturates at 15; first_err a=0, b=0, f=000.
//  5. rst_n low for one cycle at vector 100
//     -> next cycle all outputs 0, IDLE; a later start runs the full 512 cycles and passes.
//  6. start held high through the whole run, then re-pulsed in DONE
//     -> exactly one sweep while busy; the second start clears done/err_count and runs again, SETTLE=0 variant taking 256 cycles.

Source files
------------

// File: rtl/comparator_sweep_checker_pkg.sv
// Shared state encoding, flag bit positions and the golden comparison used
// by the sweep checker.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  // Operands are zero-extended to 32 bits by the caller, so the compare is unsigned.
  function automatic logic [2:0] exp_flags(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f;
    f          = '0;
    f[FLAG_EQ] = (a == b);
    f[FLAG_GT] = (a > b);
    f[FLAG_LT] = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/comparator_sweep_checker_vector_gen.sv
// Operand pair counter for the sweep: clear, advance, and a wrap strobe that
// fires on the advance that rolls the counter back to zero.
module cmp_vector_gen #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             wrap_o
);

  logic [VEC_W-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (clr_i) begin
      vec_d = '0;
    end else if (adv_i) begin
      vec_d = vec_q + VEC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec_o  = vec_q;
  assign wrap_o = adv_i && !clr_i && (vec_q == '1);

endmodule

// File: rtl/comparator_sweep_checker.sv
// Exhaustive A/B sweep driver and checker for a magnitude comparator: counts
// mismatching vectors (saturating) and captures the first failing vector.
module comparator_sweep_checker
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A_o,
  output logic [WIDTH-1:0] B_o,
  input  logic             AeB_i,
  input  logic             AgB_i,
  input  logic             AlB_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [2:0]       first_err_f
);

  localparam int                 CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [ERR_W-1:0]   ERR_MAX     = '1;
  // With no settle time every cycle is a check cycle.
  localparam state_e             ST_RUN      = (SETTLE == 0) ? ST_CHECK : ST_WAIT;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic [2:0]         ff_q, ff_d;
  logic               clr, adv, wrap, mism;
  logic [2*WIDTH-1:0] vec;
  logic [2:0]         obs_flags;

  cmp_vector_gen #(.VEC_W(2 * WIDTH)) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .adv_i  (adv),
    .vec_o  (vec),
    .wrap_o (wrap)
  );

  assign A_o       = vec[2*WIDTH-1:WIDTH];
  assign B_o       = vec[WIDTH-1:0];
  assign obs_flags = {AeB_i, AgB_i, AlB_i};
  assign mism      = (obs_flags != exp_flags(32'(A_o), 32'(B_o)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    ff_d    = ff_q;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          ff_d    = '0;
          clr     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // A zero count means no mismatch has been captured yet this sweep.
        if (mism) begin
          err_d = sat_inc(err_q);
          if (err_q == '0) begin
            fa_d = A_o;
            fb_d = B_o;
            ff_d = obs_flags;
          end
        end
        adv     = 1'b1;
        cnt_d   = '0;
        state_d = wrap ? ST_DONE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      ff_q    <= ff_d;
    end
  end

  assign busy        = (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (err_q == '0);
  assign err_count   = err_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;
  assign first_err_f = ff_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Scoreboard bench: two checker instances (SETTLE=1/ERR_W=16 and
// SETTLE=0/ERR_W=4) each driving a behavioural comparator with selectable faults.
module tb_comparator_sweep_checker;

  typedef struct {
    int         errc;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    logic       pass;
    int         cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [2];
  logic [3:0]  a_s [2], b_s [2], fa_s [2], fb_s [2];
  logic [2:0]  f_s [2], ff_s [2];
  logic        busy_s [2], done_s [2], pass_s [2];
  logic [15:0] ec_s [2];
  logic [15:0] ec0;
  logic [3:0]  ec1;
  int          mode_s [2];
  logic [2:0]  rmask [2][256];
  exp_t        q0 [$], q1 [$];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  // Comparator behaviour, optionally faulted: 1=AgB stuck 0, 2=AgB/AlB swapped,
  // 3=all flags 0, 4=random per-vector bit flips.
  function automatic logic [2:0] fault_flags(input int mode, input logic [3:0] a,
                                             input logic [3:0] b, input logic [2:0] m);
    logic [2:0] r;
    r = {a == b, a > b, a < b};
    case (mode)
      1: r[1] = 1'b0;
      2: r = {r[2], r[0], r[1]};
      3: r = 3'b000;
      4: r = r ^ m;
      default: ;
    endcase
    return r;
  endfunction

  function automatic exp_t model(input int d, input int mode, input int errw, input int settle);
    exp_t e;
    bit found;
    logic [2:0] o, ideal;
    e.errc = 0; e.a = '0; e.b = '0; e.f = '0; found = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ideal = {a == b, a > b, a < b};
        o     = fault_flags(mode, 4'(a), 4'(b), rmask[d][a*16+b]);
        if (o != ideal) begin
          if (!found) begin
            e.a = 4'(a); e.b = 4'(b); e.f = o; found = 1;
          end
          if (e.errc < (1 << errw) - 1) e.errc++;
        end
      end
    end
    e.pass   = (e.errc == 0);
    e.cycles = 256 * (settle + 1);
    return e;
  endfunction

  assign f_s[0]  = fault_flags(mode_s[0], a_s[0], b_s[0], rmask[0][{a_s[0], b_s[0]}]);
  assign f_s[1]  = fault_flags(mode_s[1], a_s[1], b_s[1], rmask[1][{a_s[1], b_s[1]}]);
  assign ec_s[0] = ec0;
  assign ec_s[1] = {12'd0, ec1};

  comparator_sweep_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .A_o(a_s[0]), .B_o(b_s[0]),
    .AeB_i(f_s[0][2]), .AgB_i(f_s[0][1]), .AlB_i(f_s[0][0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(ec0),
    .first_err_a(fa_s[0]), .first_err_b(fb_s[0]), .first_err_f(ff_s[0])
  );

  comparator_sweep_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(4)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .A_o(a_s[1]), .B_o(b_s[1]),
    .AeB_i(f_s[1][2]), .AgB_i(f_s[1][1]), .AlB_i(f_s[1][0]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(ec1),
    .first_err_a(fa_s[1]), .first_err_b(fb_s[1]), .first_err_f(ff_s[1])
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input int d, input string tag);
    chk({tag, "_busy"}, busy_s[d], 0);
    chk({tag, "_done"}, done_s[d], 0);
    chk({tag, "_pass"}, pass_s[d], 0);
    chk({tag, "_errc"}, ec_s[d], 0);
    chk({tag, "_a"}, a_s[d], 0);
    chk({tag, "_b"}, b_s[d], 0);
    chk({tag, "_fa"}, fa_s[d], 0);
    chk({tag, "_fb"}, fb_s[d], 0);
    chk({tag, "_ff"}, ff_s[d], 0);
  endtask

  task automatic prep_run(input int d, input int mode, input bit push);
    exp_t e;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    mode_s[d] = mode;
    if (mode == 4)
      for (int i = 0; i < 256; i++)
        rmask[d][i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    if (push) begin
      e = model(d, mode, (d == 0) ? 16 : 4, (d == 0) ? 1 : 0);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic start_run(input int d, input int mode, input bit push);
    prep_run(d, mode, push);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    chk("busy_rise", busy_s[d], 1);
    chk("done_clr", done_s[d], 0);
    chk("errc_clr", ec_s[d], 0);
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!done_s[d] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done_s[d], 1);
  endtask

  // Monitor: measures busy length and checks each completed sweep against the queue.
  initial begin
    logic busy_prev [2];
    logic done_prev [2];
    int   bcnt [2];
    exp_t e;
    bit   have;
    busy_prev = '{1'b0, 1'b0};
    done_prev = '{1'b0, 1'b0};
    bcnt      = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (busy_s[d] === 1'b1 && busy_prev[d] !== 1'b1) bcnt[d] = 0;
        if (busy_s[d] === 1'b1) bcnt[d]++;
        if (done_s[d] === 1'b1 && done_prev[d] !== 1'b1) begin
          have = 0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
          if (!have) begin
            chk("unexpected_done", d, -1);
          end else begin
            chk("err_count", ec_s[d], e.errc);
            chk("first_err_a", fa_s[d], e.a);
            chk("first_err_b", fb_s[d], e.b);
            chk("first_err_f", ff_s[d], e.f);
            chk("pass", pass_s[d], e.pass);
            chk("busy_cycles", bcnt[d], e.cycles);
          end
        end
        busy_prev[d] = busy_s[d];
        done_prev[d] = done_s[d];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    mode_s[0]  = 0;
    mode_s[1]  = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) rmask[d][i] = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero(0, "rst0");
    chk_all_zero(1, "rst1");

    // Correct, AgB stuck, swapped and two random-fault sweeps.
    start_run(0, 0, 1); wait_done(0);
    start_run(0, 1, 1); wait_done(0);
    start_run(0, 2, 1); wait_done(0);
    start_run(0, 4, 1); wait_done(0);
    start_run(0, 4, 1); wait_done(0);
    repeat (3) @(negedge clk);
    chk("done_held", done_s[0], 1);

    // Saturation with a 4-bit counter, all flags stuck low.
    start_run(1, 3, 1); wait_done(1);

    // Reset in the middle of a faulty sweep, at vector 100.
    start_run(0, 1, 0);
    n = 0;
    while (!(a_s[0] == 4'd6 && b_s[0] == 4'd4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec100", {a_s[0], b_s[0]}, 100);
    chk("errc_before_rst", (ec_s[0] != 0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero(0, "midrst");
    repeat (4) @(negedge clk);
    chk("idle_after_rst", busy_s[0], 0);
    start_run(0, 0, 1); wait_done(0);

    // start held through a SETTLE=0 sweep, then re-pulsed in DONE.
    prep_run(1, 1, 1);
    start_s[1] = 1'b1;
    @(negedge clk);
    chk("held_busy_rise", busy_s[1], 1);
    repeat (200) @(negedge clk);
    chk("held_still_busy", busy_s[1], 1);
    start_s[1] = 1'b0;
    wait_done(1);
    repeat (5) @(negedge clk);
    chk("held_done_stays", done_s[1], 1);
    start_run(1, 0, 1); wait_done(1);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
